// File: rtl/decode_module_pkg.sv
// Purpose: shared opcode/funct encodings, control bundle layout and decode helpers for the ID stage.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package decode_module_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0]); resolved by the ALU control in EX
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_RTYPE = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_SLT   = 3'd5,
        ALU_LUI   = 3'd6,
        ALU_LINK  = 3'd7
    } alu_op_e;

    // Bit order, MSB first: reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[2:0]
    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        alu_op_e alu_op;
    } ctrl_t;

    localparam int    CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_RTYPE; end
            OP_LW:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1;
                            c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
            OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
            OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
            OP_ANDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
            OP_ORI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR;  end
            OP_SLTI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SLT; end
            OP_LUI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_LUI; end
            OP_BEQ,
            OP_BNE:   c.alu_op = ALU_SUB;
            OP_JAL:   begin c.reg_write = 1'b1; c.alu_op = ALU_LINK; end
            default:  c = CTRL_NOP;   // j and unknown opcodes write nothing
        endcase
        return c;
    endfunction

    // Instructions whose rt field is a source operand (not a destination)
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/decode_module_if.sv
// Purpose: IF/ID, write-back, hazard-source and ID/EX signal bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: stall is signalled through o_pc_we/o_if_id_we; no valid/ready.
interface decode_module_if #(
    parameter int NB_BITS = 32,
    parameter int NB_JMP  = 26,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 9
);
    logic [NB_BITS-1:0] i_if_id_pc;
    logic [NB_BITS-1:0] i_if_id_instr;
    logic               i_wb_we;
    logic [NB_REG-1:0]  i_wb_addr;
    logic [NB_BITS-1:0] i_wb_data;
    logic               i_ex_reg_write;
    logic               i_ex_mem_read;
    logic [NB_REG-1:0]  i_ex_wr_reg;
    logic               i_mem_mem_read;
    logic [NB_REG-1:0]  i_mem_wr_reg;

    logic [NB_BITS-1:0] o_brq_addr;
    logic [NB_JMP-1:0]  o_jmp_addr;
    logic               o_ctr_beq;
    logic               o_ctr_jmp;
    logic               o_ctr_flush;
    logic               o_pc_we;
    logic               o_if_id_we;
    logic [NB_BITS-1:0] o_id_ex_pc;
    logic [NB_BITS-1:0] o_id_ex_rs_data;
    logic [NB_BITS-1:0] o_id_ex_rt_data;
    logic [NB_BITS-1:0] o_id_ex_imm;
    logic [NB_REG-1:0]  o_id_ex_rs;
    logic [NB_REG-1:0]  o_id_ex_rt;
    logic [NB_REG-1:0]  o_id_ex_rd;
    logic [NB_CTRL-1:0] o_id_ex_ctrl;

    // master: the pipeline around decode (drives inputs); slave: the decode stage
    modport master (
        output i_if_id_pc, i_if_id_instr, i_wb_we, i_wb_addr, i_wb_data,
               i_ex_reg_write, i_ex_mem_read, i_ex_wr_reg, i_mem_mem_read, i_mem_wr_reg,
        input  o_brq_addr, o_jmp_addr, o_ctr_beq, o_ctr_jmp, o_ctr_flush, o_pc_we, o_if_id_we,
               o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm,
               o_id_ex_rs, o_id_ex_rt, o_id_ex_rd, o_id_ex_ctrl
    );
    modport slave (
        input  i_if_id_pc, i_if_id_instr, i_wb_we, i_wb_addr, i_wb_data,
               i_ex_reg_write, i_ex_mem_read, i_ex_wr_reg, i_mem_mem_read, i_mem_wr_reg,
        output o_brq_addr, o_jmp_addr, o_ctr_beq, o_ctr_jmp, o_ctr_flush, o_pc_we, o_if_id_we,
               o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm,
               o_id_ex_rs, o_id_ex_rt, o_id_ex_rd, o_id_ex_ctrl
    );
endinterface

// File: rtl/decode_module_register_file.sv
// Purpose: 2**NB_REG x NB_BITS register file, r0 hard-wired to zero, write-to-read bypass.
// Latency: reads combinational; write lands on the rising edge.
// Backpressure: none; always accepts a write.
// Ports: i_clk/i_rst_n, write port i_we/i_waddr/i_wdata, read ports i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b.
module register_file #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [NB_REG-1:0]  i_waddr,
    input  logic [NB_BITS-1:0] i_wdata,
    input  logic [NB_REG-1:0]  i_raddr_a,
    output logic [NB_BITS-1:0] o_rdata_a,
    input  logic [NB_REG-1:0]  i_raddr_b,
    output logic [NB_BITS-1:0] o_rdata_b
);
    localparam int NREGS = 2 ** NB_REG;

    logic [NB_BITS-1:0] mem [NREGS];
    logic               wr_ok;

    assign wr_ok = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass lets the ID stage see a value being written back in the same cycle.
    always_comb begin
        o_rdata_a = mem[i_raddr_a];
        if (i_raddr_a == '0)                     o_rdata_a = '0;
        else if (wr_ok && i_waddr == i_raddr_a)  o_rdata_a = i_wdata;
    end

    always_comb begin
        o_rdata_b = mem[i_raddr_b];
        if (i_raddr_b == '0)                     o_rdata_b = '0;
        else if (wr_ok && i_waddr == i_raddr_b)  o_rdata_b = i_wdata;
    end
endmodule

// File: rtl/decode_module.sv
// Purpose: ID stage - decode, register read, hazard stall, branch/jump resolution, ID/EX register.
// Latency: fetch controls and redirect combinational; ID/EX outputs 1 cycle.
// Backpressure: on load-use or branch hazard drops o_pc_we/o_if_id_we and inserts an all-zero bubble.
// Ports: i_clk, i_rst_n, bus (decode_module_if.slave: IF/ID in, WB in, EX/MEM hazard info in, fetch ctrl + ID/EX out).
module decode_module
    import decode_module_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_JMP  = 26,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 9
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    decode_module_if.slave bus
);
    logic [NB_BITS-1:0] instr;
    logic [5:0]         opcode;
    logic [NB_REG-1:0]  rs, rt, rd;
    logic [NB_BITS-1:0] rs_data, rt_data;
    logic [NB_BITS-1:0] imm_sext, imm_ext;
    ctrl_t              dec_ctrl;
    logic               is_br, is_jmp, taken;
    logic               load_use, br_stall, stall;

    assign instr    = bus.i_if_id_instr;
    assign opcode   = instr[31:26];
    assign rs       = NB_REG'(instr[25:21]);
    assign rt       = NB_REG'(instr[20:16]);
    assign dec_ctrl = decode_ctrl(opcode);
    assign imm_sext = {{(NB_BITS-16){instr[15]}}, instr[15:0]};

    register_file #(.NB_BITS(NB_BITS), .NB_REG(NB_REG)) u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (bus.i_wb_we),
        .i_waddr   (bus.i_wb_addr),
        .i_wdata   (bus.i_wb_data),
        .i_raddr_a (rs),
        .o_rdata_a (rs_data),
        .i_raddr_b (rt),
        .o_rdata_b (rt_data)
    );

    always_comb begin
        imm_ext = imm_sext;
        if (opcode == OP_ANDI || opcode == OP_ORI) imm_ext = NB_BITS'(instr[15:0]);
        else if (opcode == OP_LUI)                 imm_ext = NB_BITS'({instr[15:0], 16'h0000});
    end

    always_comb begin
        rd = rt;
        if (opcode == OP_RTYPE)    rd = NB_REG'(instr[15:11]);
        else if (opcode == OP_JAL) rd = NB_REG'(31);
    end

    // Hazard detection: a load in EX feeding any source, or a branch whose
    // comparands are still being produced by EX or loaded in MEM.
    assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jmp   = (opcode == OP_J)   || (opcode == OP_JAL);
    assign load_use = bus.i_ex_mem_read && (bus.i_ex_wr_reg != '0) &&
                      ((bus.i_ex_wr_reg == rs) || (uses_rt(opcode) && bus.i_ex_wr_reg == rt));
    assign br_stall = is_br && (
        ((rs != '0) && ((bus.i_ex_reg_write && bus.i_ex_wr_reg == rs) ||
                        (bus.i_mem_mem_read && bus.i_mem_wr_reg == rs))) ||
        ((rt != '0) && ((bus.i_ex_reg_write && bus.i_ex_wr_reg == rt) ||
                        (bus.i_mem_mem_read && bus.i_mem_wr_reg == rt))));
    assign stall    = load_use || br_stall;

    assign taken = ((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                   ((opcode == OP_BNE) && (rs_data != rt_data));

    assign bus.o_brq_addr  = bus.i_if_id_pc + (imm_sext << 2);
    assign bus.o_jmp_addr  = {instr[NB_JMP-3:0], 2'b00};
    assign bus.o_ctr_beq   = !stall && taken;
    assign bus.o_ctr_jmp   = !stall && is_jmp;
    assign bus.o_ctr_flush = !stall && (taken || is_jmp);
    assign bus.o_pc_we     = !stall;
    assign bus.o_if_id_we  = !stall;

    // ID/EX pipeline register
    logic [NB_BITS-1:0] q_pc, q_rs_data, q_rt_data, q_imm;
    logic [NB_REG-1:0]  q_rs, q_rt, q_rd;
    logic [NB_CTRL-1:0] q_ctrl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || stall) begin
            q_pc      <= '0;
            q_rs_data <= '0;
            q_rt_data <= '0;
            q_imm     <= '0;
            q_rs      <= '0;
            q_rt      <= '0;
            q_rd      <= '0;
            q_ctrl    <= NB_CTRL'(CTRL_NOP);
        end else begin
            q_pc      <= bus.i_if_id_pc;
            q_rs_data <= rs_data;
            q_rt_data <= rt_data;
            q_imm     <= imm_ext;
            q_rs      <= rs;
            q_rt      <= rt;
            q_rd      <= rd;
            q_ctrl    <= NB_CTRL'(dec_ctrl);
        end
    end

    assign bus.o_id_ex_pc      = q_pc;
    assign bus.o_id_ex_rs_data = q_rs_data;
    assign bus.o_id_ex_rt_data = q_rt_data;
    assign bus.o_id_ex_imm     = q_imm;
    assign bus.o_id_ex_rs      = q_rs;
    assign bus.o_id_ex_rt      = q_rt;
    assign bus.o_id_ex_rd      = q_rd;
    assign bus.o_id_ex_ctrl    = q_ctrl;
endmodule

// File: tb/tb_decode_module.sv
// Purpose: self-checking bench for decode_module; scoreboard of expected ID/EX contents per cycle.
// Latency: expects ID/EX one edge after the instruction is presented.
// Backpressure: expected stall flags are given per vector.
module tb_decode_module;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_module_if #(.NB_BITS(32), .NB_JMP(26), .NB_REG(5), .NB_CTRL(9)) bus ();

    decode_module #(.NB_BITS(32), .NB_JMP(26), .NB_REG(5), .NB_CTRL(9)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] pc, rs_d, rt_d, imm;
        logic [4:0]  rs, rt, rd;
        logic [8:0]  ctrl;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bus.i_wb_we && bus.i_wb_addr == a) return bus.i_wb_data;
        return mregs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
        exp_t        e;
        logic [5:0]  op;
        op     = instr[31:26];
        e.pc   = pc;
        e.rs   = instr[25:21];
        e.rt   = instr[20:16];
        e.rs_d = mread(e.rs);
        e.rt_d = mread(e.rt);
        e.rd   = (op == 6'h00) ? instr[15:11] : (op == 6'h03) ? 5'd31 : instr[20:16];
        e.imm  = {{16{instr[15]}}, instr[15:0]};
        if (op == 6'h0C || op == 6'h0D) e.imm = {16'h0, instr[15:0]};
        if (op == 6'h0F)                e.imm = {instr[15:0], 16'h0};
        case (op)
            6'h00:   e.ctrl = 9'b1_0000_1_010;
            6'h23:   e.ctrl = 9'b1_1101_0_000;
            6'h2B:   e.ctrl = 9'b0_0011_0_000;
            6'h08:   e.ctrl = 9'b1_0001_0_000;
            6'h0C:   e.ctrl = 9'b1_0001_0_011;
            6'h0D:   e.ctrl = 9'b1_0001_0_100;
            6'h0A:   e.ctrl = 9'b1_0001_0_101;
            6'h0F:   e.ctrl = 9'b1_0001_0_110;
            6'h04,
            6'h05:   e.ctrl = 9'b0_0000_0_001;
            6'h03:   e.ctrl = 9'b1_0000_0_111;
            default: e.ctrl = 9'b0;
        endcase
        return e;
    endfunction

    task automatic clear_side();
        bus.i_wb_we        = 1'b0;
        bus.i_wb_addr      = 5'd0;
        bus.i_wb_data      = 32'h0;
        bus.i_ex_reg_write = 1'b0;
        bus.i_ex_mem_read  = 1'b0;
        bus.i_ex_wr_reg    = 5'd0;
        bus.i_mem_mem_read = 1'b0;
        bus.i_mem_wr_reg   = 5'd0;
    endtask

    // One instruction in ID: checks fetch controls before the edge, ID/EX after it.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc,
                        input bit stl, input bit beq, input bit jmp);
        exp_t        e;
        logic [31:0] sext;
        @(negedge clk);
        bus.i_if_id_instr = instr;
        bus.i_if_id_pc    = pc;
        #1;
        sext = {{16{instr[15]}}, instr[15:0]};
        check("pc_we",    32'(bus.o_pc_we),     32'(!stl));
        check("if_id_we", 32'(bus.o_if_id_we),  32'(!stl));
        check("ctr_beq",  32'(bus.o_ctr_beq),   32'(beq));
        check("ctr_jmp",  32'(bus.o_ctr_jmp),   32'(jmp));
        check("flush",    32'(bus.o_ctr_flush), 32'(beq | jmp));
        check("brq_addr", bus.o_brq_addr,       pc + (sext << 2));
        check("jmp_addr", 32'(bus.o_jmp_addr),  32'({instr[23:0], 2'b00}));
        e = stl ? exp_t'('0) : model(instr, pc);
        sb.push_back(e);
        @(posedge clk);
        if (bus.i_wb_we && bus.i_wb_addr != 5'd0) mregs[bus.i_wb_addr] = bus.i_wb_data;
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("id_ex_pc",   bus.o_id_ex_pc,             e.pc);
            check("id_ex_rs_d", bus.o_id_ex_rs_data,        e.rs_d);
            check("id_ex_rt_d", bus.o_id_ex_rt_data,        e.rt_d);
            check("id_ex_imm",  bus.o_id_ex_imm,            e.imm);
            check("id_ex_rs",   32'(bus.o_id_ex_rs),        32'(e.rs));
            check("id_ex_rt",   32'(bus.o_id_ex_rt),        32'(e.rt));
            check("id_ex_rd",   32'(bus.o_id_ex_rd),        32'(e.rd));
            check("id_ex_ctrl", 32'(bus.o_id_ex_ctrl),      32'(e.ctrl));
        end
        clear_side();
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        clear_side();
        bus.i_if_id_instr = 32'h0;
        bus.i_if_id_pc    = 32'h0;

        // Reset state
        #23;
        check("rst_ctrl", 32'(bus.o_id_ex_ctrl), 32'h0);
        check("rst_rs_d", bus.o_id_ex_rs_data,    32'h0);
        check("rst_pc",   bus.o_id_ex_pc,         32'h0);
        check("rst_pcwe", 32'(bus.o_pc_we),       32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // WB bypass into the instruction being decoded
        wb(5'd1, 32'd5);           step(32'h00221820, 32'h04, 0, 0, 0);  // add r3,r1,r2
        wb(5'd2, 32'd7);           step(32'h2004FFFF, 32'h08, 0, 0, 0);  // addi r4,r0,-1
        wb(5'd1, 32'd7);           step(32'h34258001, 32'h0C, 0, 0, 0);  // ori r5,r1,0x8001

        // Load-use hazards
        bus.i_ex_mem_read = 1'b1; bus.i_ex_wr_reg = 5'd2;
        step(32'h00441820, 32'h10, 1, 0, 0);                             // add r3,r2,r4: rs hit
        bus.i_ex_mem_read = 1'b1; bus.i_ex_wr_reg = 5'd2;
        step(32'hAC220008, 32'h14, 1, 0, 0);                             // sw r2,8(r1): rt hit
        bus.i_ex_mem_read = 1'b1; bus.i_ex_wr_reg = 5'd6;
        step(32'h8C660004, 32'h18, 0, 0, 0);                             // lw r6,4(r3): rt is dest

        // Branches (r1 == r2 == 7)
        step(32'h10220003, 32'h10, 0, 1, 0);                             // beq taken, target 0x1C
        step(32'h14220003, 32'h10, 0, 0, 0);                             // bne not taken
        bus.i_ex_reg_write = 1'b1; bus.i_ex_wr_reg = 5'd1;
        step(32'h10220003, 32'h10, 1, 0, 0);                             // beq, rs produced in EX
        bus.i_mem_mem_read = 1'b1; bus.i_mem_wr_reg = 5'd2;
        step(32'h10220003, 32'h10, 1, 0, 0);                             // beq, rt loaded in MEM

        // Jumps
        step(32'h08000040, 32'h20, 0, 0, 1);                             // j 0x40 -> 0x100
        step(32'h0C000040, 32'h24, 0, 0, 1);                             // jal 0x40

        // r0 stays zero
        wb(5'd0, 32'd9);           step(32'h00001820, 32'h28, 0, 0, 0);  // add r3,r0,r0
        step(32'h00001820, 32'h2C, 0, 0, 0);

        // Remaining I-types and an unknown opcode
        step(32'h3C071234, 32'h30, 0, 0, 0);                             // lui
        step(32'h2828FFFE, 32'h34, 0, 0, 0);                             // slti
        step(32'h3029FFFF, 32'h38, 0, 0, 0);                             // andi
        step(32'hAC220008, 32'h3C, 0, 0, 0);                             // sw
        step(32'hFC000000, 32'h40, 0, 0, 0);                             // illegal -> ctrl 0

        // Write-back still lands while stalled
        bus.i_ex_mem_read = 1'b1; bus.i_ex_wr_reg = 5'd2;
        wb(5'd10, 32'h55);         step(32'h00441820, 32'h44, 1, 0, 0);
        step(32'h01401820, 32'h48, 0, 0, 0);                             // add r3,r10,r0

        // Reset between edges after a lw was loaded
        step(32'h8C660004, 32'h4C, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 32'(bus.o_id_ex_ctrl), 32'h0);
        check("mid_rst_rs_d", bus.o_id_ex_rs_data,    32'h0);
        check("mid_rst_pc",   bus.o_id_ex_pc,         32'h0);
        check("mid_rst_rd",   32'(bus.o_id_ex_rd),    32'h0);
        check("mid_rst_pcwe", 32'(bus.o_pc_we),       32'h1);
        bus.i_ex_mem_read = 1'b1; bus.i_ex_wr_reg = 5'd3;   // lw still in ID uses rs=r3
        #1;
        check("rst_hazard_pcwe", 32'(bus.o_pc_we), 32'h0);
        clear_side();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h00221820, 32'h50, 0, 0, 0);                             // r1/r2 cleared
        step(32'h01401820, 32'h54, 0, 0, 0);                             // r10 cleared

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
